// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and opcode legality helper for alu_arbiter
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [OP_W-1:0] ALU_SHL = 4'd5;
    localparam logic [OP_W-1:0] ALU_SHR = 4'd6;
    localparam logic [OP_W-1:0] ALU_MUL = 4'd7;
    localparam logic [OP_W-1:0] ALU_DIV = 4'd8;
    localparam logic [OP_W-1:0] ALU_MOD = 4'd9;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return op <= ALU_MOD;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational n-bit ALU producing result and {Z,N,V,C}
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int n = 4
) (
    input  logic [OP_W-1:0] op,
    input  logic [n-1:0]    a,
    input  logic [n-1:0]    b,
    output logic [n-1:0]    result,
    output logic [3:0]      flags
);

    logic [n:0]   sum;
    logic [n-1:0] res;
    logic         c;
    logic         v;

    // C is carry-out for ADD and borrow for SUB; V is signed overflow; other ops clear both
    always_comb begin
        sum = '0;
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            ALU_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[n-1:0];
                c   = sum[n];
                v   = (a[n-1] == b[n-1]) && (res[n-1] != a[n-1]);
            end
            ALU_SUB: begin
                sum = {1'b0, a} - {1'b0, b};
                res = sum[n-1:0];
                c   = sum[n];
                v   = (a[n-1] != b[n-1]) && (res[n-1] != a[n-1]);
            end
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_SHL: res = a << b;
            ALU_SHR: res = a >> b;
            ALU_MUL: res = a * b;
            ALU_DIV: res = (b == '0) ? '0 : a / b;
            ALU_MOD: res = (b == '0) ? '0 : a % b;
            default: res = '0;
        endcase
    end

    assign result = res;
    assign flags  = {(res == '0), res[n-1], v, c};

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two valid/ready requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int n     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [n-1:0]     req0_a,
    input  logic [n-1:0]     req0_b,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [n-1:0]     req1_a,
    input  logic [n-1:0]     req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [n-1:0]     rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t          state, next_state;
    logic            rr_ptr;
    logic            grant_id;
    logic [1:0]      ready_c;
    logic [OP_W-1:0] cap_op;
    logic [n-1:0]    cap_a, cap_b;
    logic            cap_id;
    logic [n-1:0]    alu_result;
    logic [3:0]      alu_flags;
    logic            op_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // rr_ptr names the requester that wins when both are valid
    always_comb begin
        next_state = state;
        ready_c    = 2'b00;
        grant_id   = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_id   = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
                    ready_c    = grant_id ? 2'b10 : 2'b01;
                    next_state = EXEC;
                end
            end
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign req_ready = ready_c;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    assign op_err = !is_legal_op(cap_op) ||
                    (((cap_op == ALU_DIV) || (cap_op == ALU_MOD)) && (cap_b == '0));

    alu_arbiter_alu #(.n(n)) u_alu (
        .op     (cap_op),
        .a      (cap_a),
        .b      (cap_b),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= 1'b0;
            cap_op     <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            cap_id     <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
        end else begin
            if ((state == IDLE) && (|req_valid)) begin
                cap_id <= grant_id;
                cap_op <= grant_id ? req1_op : req0_op;
                cap_a  <= grant_id ? req1_a  : req0_a;
                cap_b  <= grant_id ? req1_b  : req0_b;
            end
            if (state == EXEC) begin
                rsp_id     <= cap_id;
                rsp_err    <= op_err;
                rsp_result <= op_err ? '0 : alu_result;
                rsp_flags  <= op_err ? 4'b0000 : alu_flags;
                rr_ptr     <= ~cap_id;
            end
            if ((state == RESP) && rsp_ready && (op_count != '1))
                op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter against an arithmetic model
module tb_alu_arbiter;

    localparam int N     = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [3:0]       req0_op, req1_op;
    logic [N-1:0]     req0_a, req0_b, req1_a, req1_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [N-1:0]     rsp_result;
    logic [3:0]       rsp_flags;
    logic             rsp_err;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int tests = 0;
    int fails = 0;
    int last_id;
    int exp_count;

    alu_arbiter #(.n(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // {err, Z, N, V, C, result} from plain integer arithmetic on 4-bit values
    function automatic logic [8:0] model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia, ib, sa, sb, r, s;
        logic c, v, z, ng;
        ia = int'(a); ib = int'(b);
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        r = 0; c = 1'b0; v = 1'b0;
        if (ia < 0 || int'(op) > 9 || ((int'(op) == 8 || int'(op) == 9) && ib == 0))
            return 9'h100;
        case (int'(op))
            0: begin s = ia + ib; r = s % 16; c = (s >= 16); v = (sa + sb > 7) || (sa + sb < -8); end
            1: begin r = (ia - ib + 16) % 16; c = (ia < ib); v = (sa - sb > 7) || (sa - sb < -8); end
            2: r = ia & ib;
            3: r = ia | ib;
            4: r = ia ^ ib;
            5: r = (ib >= 4) ? 0 : (ia * (1 << ib)) % 16;
            6: r = (ib >= 4) ? 0 : ia / (1 << ib);
            7: r = (ia * ib) % 16;
            8: r = ia / ib;
            default: r = ia % ib;
        endcase
        z  = (r == 0);
        ng = (r >= 8);
        return {1'b0, z, ng, v, c, r[3:0]};
    endfunction

    function automatic int exp_grant(input logic [1:0] v);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return (last_id == 0) ? 1 : 0;
    endfunction

    task automatic do_reset;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        last_id = 1; exp_count = 0;
    endtask

    // Runs one request from an IDLE negedge through the consuming edge; operands are scrambled after accept
    task automatic transact(input logic [1:0] v,
                            input logic [3:0] o0, input logic [3:0] a0, input logic [3:0] b0,
                            input logic [3:0] o1, input logic [3:0] a1, input logic [3:0] b1,
                            input int hold,
                            output logic [1:0] rdy, output logic early, output logic late,
                            output logic [8:0] rsp, output logic id, output logic stable);
        req_valid = v;
        req0_op = o0; req0_a = a0; req0_b = b0;
        req1_op = o1; req1_a = a1; req1_b = b1;
        #1 rdy = req_ready;
        @(negedge clk);
        early = rsp_valid;
        req0_op = 4'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
        req1_op = 4'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
        rsp_ready = 1'($urandom);
        @(negedge clk);
        rsp_ready = 1'b0;
        late = rsp_valid;
        rsp = {rsp_err, rsp_flags, rsp_result};
        id = rsp_id;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if ({rsp_err, rsp_flags, rsp_result} !== rsp || rsp_id !== id || req_ready !== 2'b00 ||
                busy !== 1'b1 || rsp_valid !== 1'b1)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0;
        req0_op = 0; req0_a = 0; req0_b = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({rsp_valid, req_ready, busy, op_count} !== '0) begin
            fails++;
            $display("FAIL reset_ctrl: got valid=%b ready=%b busy=%b cnt=%0d expected all 0", rsp_valid, req_ready, busy, op_count);
        end
        tests++;
        if ({rsp_id, rsp_err, rsp_flags, rsp_result} !== '0) begin
            fails++;
            $display("FAIL reset_rsp: got id=%b err=%b flags=%b res=%h expected all 0", rsp_id, rsp_err, rsp_flags, rsp_result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        last_id = 1; exp_count = 0;
    endtask

    task automatic test_basic;
        logic [1:0] rdy; logic early, late, id, st; logic [8:0] rsp;
        transact(2'b01, 4'd0, 4'd3, 4'd5, 4'd0, 4'd0, 4'd0, 0, rdy, early, late, rsp, id, st);
        req_valid = 2'b00;
        last_id = 0; exp_count++;
        tests++;
        if (rdy !== 2'b01) begin fails++; $display("FAIL basic_ready: got %b expected 01", rdy); end
        tests++;
        if ({early, late} !== 2'b01) begin fails++; $display("FAIL basic_latency: got T+1=%b T+2=%b expected 0,1", early, late); end
        tests++;
        if ({id, rsp} !== {1'b0, 9'b0_0110_1000}) begin fails++; $display("FAIL basic_rsp: got id=%b rsp=%b expected id=0 rsp=001101000", id, rsp); end
        tests++;
        if ({rsp_valid, op_count} !== {1'b0, 8'd1}) begin fails++; $display("FAIL basic_count: got valid=%b cnt=%0d expected 0,1", rsp_valid, op_count); end
    endtask

    task automatic test_contention;
        logic [1:0] rdy; logic early, late, id, st; logic [8:0] rsp;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            transact(2'b11, 4'd1, 4'd10, 4'd4, 4'd2, 4'b1010, 4'b1100, 0, rdy, early, late, rsp, id, st);
            tests++;
            if (rdy !== (k == 0 ? 2'b01 : 2'b10) || id !== 1'(k)) begin
                fails++; $display("FAIL contention_grant%0d: got ready=%b id=%b expected grant %0d", k, rdy, id, k);
            end
            tests++;
            if (rsp[3:0] !== (k == 0 ? 4'd6 : 4'b1000) || rsp !== (k == 0 ? model(4'd1, 4'd10, 4'd4) : model(4'd2, 4'd10, 4'd12))) begin
                fails++; $display("FAIL contention_rsp%0d: got %b", k, rsp);
            end
        end
        req_valid = 2'b00;
        last_id = 1; exp_count = 2;
    endtask

    task automatic test_backpressure;
        logic [1:0] rdy; logic early, late, id, st; logic [8:0] rsp;
        int g;
        for (int k = 0; k < 2; k++) begin
            g = exp_grant(2'b11);
            transact(2'b11, 4'd0, 4'd7, 4'd2, 4'd3, 4'd5, 4'd9, (k == 0) ? 5 : 0, rdy, early, late, rsp, id, st);
            tests++;
            if (st !== 1'b1) begin fails++; $display("FAIL backpressure_stable%0d: got %b expected 1", k, st); end
            tests++;
            if (rdy !== (g == 1 ? 2'b10 : 2'b01) || late !== 1'b1 ||
                rsp !== (g == 1 ? model(4'd3, 4'd5, 4'd9) : model(4'd0, 4'd7, 4'd2))) begin
                fails++; $display("FAIL backpressure_grant%0d: got ready=%b valid=%b rsp=%b expected grant %0d", k, rdy, late, rsp, g);
            end
            last_id = g; exp_count++;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_errors;
        logic [1:0] rdy; logic early, late, id, st; logic [8:0] rsp;
        logic [3:0] ops [4] = '{4'd8, 4'd15, 4'd8, 4'd9};
        logic [3:0] as  [4] = '{4'd12, 4'd7, 4'd12, 4'd13};
        logic [3:0] bs  [4] = '{4'd0, 4'd3, 4'd3, 4'd5};
        logic [4:0] exp [4] = '{5'h10, 5'h10, 5'h04, 5'h03};
        for (int k = 0; k < 4; k++) begin
            transact(2'b01, ops[k], as[k], bs[k], 4'd0, 4'd0, 4'd0, 0, rdy, early, late, rsp, id, st);
            last_id = 0; exp_count++;
            tests++;
            if ({rsp[8], rsp[3:0]} !== exp[k] || rsp !== model(ops[k], as[k], bs[k])) begin
                fails++; $display("FAIL error_case%0d: got err=%b flags=%b res=%0d", k, rsp[8], rsp[7:4], rsp[3:0]);
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic test_round_robin;
        logic [1:0] rdy; logic early, late, id, st; logic [8:0] rsp;
        logic [3:0] o0, a0, b0, o1, a1, b1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            o0 = 4'($urandom_range(0, 9)); a0 = 4'($urandom); b0 = 4'($urandom);
            o1 = 4'($urandom_range(0, 9)); a1 = 4'($urandom); b1 = 4'($urandom);
            transact(2'b11, o0, a0, b0, o1, a1, b1, $urandom_range(0, 2), rdy, early, late, rsp, id, st);
            tests++;
            if (id !== 1'(k % 2) || rsp !== ((k % 2) ? model(o1, a1, b1) : model(o0, a0, b0))) begin
                fails++; $display("FAIL rr_order%0d: got id=%b rsp=%b expected id=%0d", k, id, rsp, k % 2);
            end
        end
        req_valid = 2'b00;
        last_id = 1; exp_count = 4;
        tests++;
        if (op_count !== 8'd4) begin fails++; $display("FAIL rr_count: got %0d expected 4", op_count); end
    endtask

    task automatic test_random;
        logic [1:0] rdy, v; logic early, late, id, st; logic [8:0] rsp, e;
        logic [3:0] o0, a0, b0, o1, a1, b1;
        int g, bad;
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            v = 2'($urandom_range(1, 3));
            o0 = 4'($urandom); a0 = 4'($urandom); b0 = 4'($urandom_range(0, 5));
            o1 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom_range(0, 5));
            g = exp_grant(v);
            e = (g == 1) ? model(o1, a1, b1) : model(o0, a0, b0);
            transact(v, o0, a0, b0, o1, a1, b1, $urandom_range(0, 2), rdy, early, late, rsp, id, st);
            last_id = g;
            exp_count = (exp_count < 255) ? exp_count + 1 : 255;
            tests++;
            if (rdy !== (g == 1 ? 2'b10 : 2'b01) || id !== 1'(g) || {early, late} !== 2'b01 ||
                rsp !== e || st !== 1'b1 || int'(op_count) != exp_count) begin
                fails++; bad++;
                if (bad <= 8)
                    $display("FAIL random%0d: got ready=%b id=%b lat=%b%b rsp=%b cnt=%0d expected grant=%0d rsp=%b cnt=%0d",
                             k, rdy, id, early, late, rsp, op_count, g, e, exp_count);
            end
        end
        req_valid = 2'b00;
        tests++;
        if (op_count !== 8'hFF) begin fails++; $display("FAIL count_saturate: got %0d expected 255", op_count); end
    endtask

    task automatic test_reset_exec;
        logic quiet;
        @(negedge clk);
        req_valid = 2'b01; req0_op = 4'd0; req0_a = 4'd1; req0_b = 4'd1;
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({rsp_valid, busy, op_count, req_ready} !== '0) begin
            fails++; $display("FAIL reset_exec: got valid=%b busy=%b cnt=%0d ready=%b expected all 0", rsp_valid, busy, op_count, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        tests++;
        if (quiet !== 1'b1) begin fails++; $display("FAIL reset_no_rsp: got spurious response or busy"); end
        req_valid = 2'b11;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin fails++; $display("FAIL reset_priority: got %b expected 01", req_ready); end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_contention();
        test_backpressure();
        test_errors();
        test_round_robin();
        test_random();
        test_reset_exec();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
